neuron_argmax: RTL and testbench

NEURON_ARGMAX -- requirements
Module: neuron_argmax

---
 rtl/nn_pkg.sv | 14 +
 rtl/neuron_argmax_if.sv | 26 ++
 rtl/argmax_cmp.sv | 21 ++
 rtl/neuron_argmax.sv | 96 +++++++++
 tb/tb_neuron_argmax.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared constants and FSM encoding for the output-layer argmax collector.
package nn_pkg;

   localparam int NUM_CLASSES_DEF = 10;
   localparam int RES_W_DEF       = 17;
   localparam int IDX_W           = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_COLLECT = 2'd1;
   localparam state_t ST_DONE    = 2'd2;

endpackage

// File: rtl/neuron_argmax_if.sv
// Result-strobe input and classification output bundle of the argmax collector.
interface neuron_argmax_if #(
   parameter int RES_W = nn_pkg::RES_W_DEF
) ();
   import nn_pkg::*;

   logic                    start;
   logic                    result_ready;
   logic signed [RES_W-1:0] result;
   logic                    busy;
   logic                    class_valid;
   logic [IDX_W-1:0]        class_idx;
   logic signed [RES_W-1:0] max_value;
   logic                    err_unexpected;

   modport master (
      output start, result_ready, result,
      input  busy, class_valid, class_idx, max_value, err_unexpected
   );

   modport slave (
      input  start, result_ready, result,
      output busy, class_valid, class_idx, max_value, err_unexpected
   );

endinterface

// File: rtl/argmax_cmp.sv
// Signed strict-greater select; ties keep the current (lower-index) entry.
module argmax_cmp
   import nn_pkg::*;
#(
   parameter int RES_W = RES_W_DEF
) (
   input  logic signed [RES_W-1:0] cand_val_i,
   input  logic [IDX_W-1:0]        cand_idx_i,
   input  logic signed [RES_W-1:0] cur_val_i,
   input  logic [IDX_W-1:0]        cur_idx_i,
   output logic signed [RES_W-1:0] sel_val_o,
   output logic [IDX_W-1:0]        sel_idx_o
);

   logic take_cand;

   assign take_cand = (cand_val_i > cur_val_i);
   assign sel_val_o = take_cand ? cand_val_i : cur_val_i;
   assign sel_idx_o = take_cand ? cand_idx_i : cur_idx_i;

endmodule

// File: rtl/neuron_argmax.sv
// Collects NUM_CLASSES serialized neuron results and reports the signed argmax;
// class_valid pulses one cycle after the last accepted strobe. No backpressure: every strobe in COLLECT is taken.
module neuron_argmax
   import nn_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int RES_W       = RES_W_DEF
) (
   input logic            clk,
   input logic            rst_n,
   neuron_argmax_if.slave bus
);

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic signed [RES_W-1:0] max_q, max_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;
   logic                    busy_q, busy_d;

   logic signed [RES_W-1:0] sel_val;
   logic [IDX_W-1:0]        sel_idx;
   logic                    first;
   logic                    last;

   argmax_cmp #(.RES_W(RES_W)) u_cmp (
      .cand_val_i (bus.result),
      .cand_idx_i (cnt_q),
      .cur_val_i  (max_q),
      .cur_idx_i  (idx_q),
      .sel_val_o  (sel_val),
      .sel_idx_o  (sel_idx)
   );

   assign first = (cnt_q == '0);
   assign last  = (cnt_q == IDX_W'(NUM_CLASSES - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      max_d   = max_q;
      valid_d = 1'b0;
      err_d   = err_q;
      // start outranks a coincident strobe in every state
      if (bus.start) begin
         state_d = ST_COLLECT;
         cnt_d   = '0;
         idx_d   = '0;
         max_d   = '0;
         err_d   = 1'b0;
      end else if (bus.result_ready) begin
         if (state_q == ST_COLLECT) begin
            idx_d = first ? cnt_q : sel_idx;
            max_d = first ? bus.result : sel_val;
            if (last) begin
               state_d = ST_DONE;
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            err_d = 1'b1;
         end
      end
      busy_d = (state_d == ST_COLLECT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         max_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         max_q   <= max_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.busy           = busy_q;
   assign bus.class_valid    = valid_q;
   assign bus.class_idx      = idx_q;
   assign bus.max_value      = max_q;
   assign bus.err_unexpected = err_q;

endmodule

// File: tb/tb_neuron_argmax.sv
// Directed bench: driver pushes expected argmax results, a negedge monitor pops them on class_valid.
module tb_neuron_argmax;

   logic clk;
   logic rst_n;

   neuron_argmax_if #(.RES_W(17)) bus ();

   neuron_argmax #(.NUM_CLASSES(10), .RES_W(17)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int idx;
      int val;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input int v);
      bus.result_ready = 1'b1;
      bus.result       = 17'(v);
      tick();
      bus.result_ready = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic push_exp(input int idx, input int val);
      exp_t e;
      e.idx = idx;
      e.val = val;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && bus.class_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_class_valid", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("sb_class_idx", int'(bus.class_idx), e.idx);
            check("sb_max_value", int'($signed(bus.max_value)), e.val);
         end
      end
   end

   initial begin : driver
      int v1[10];
      v1 = '{5, -3, 40, 40, 7, 0, -100, 12, 39, 1};

      rst_n            = 1'b0;
      bus.start        = 1'b0;
      bus.result_ready = 1'b0;
      bus.result       = '0;
      tick();
      tick();
      check("rst_busy", int'(bus.busy), 0);
      check("rst_valid", int'(bus.class_valid), 0);
      check("rst_idx", int'(bus.class_idx), 0);
      check("rst_max", int'($signed(bus.max_value)), 0);
      check("rst_err", int'(bus.err_unexpected), 0);
      rst_n = 1'b1;
      tick();

      // back-to-back strobes, tie at index 3 must not win
      pulse_start();
      check("t1_busy", int'(bus.busy), 1);
      push_exp(2, 40);
      for (int i = 0; i < 10; i++) begin
         strobe(v1[i]);
         if (i < 9) check("t1_no_early_valid", int'(bus.class_valid), 0);
      end
      check("t1_latency_valid", int'(bus.class_valid), 1);
      check("t1_busy_done", int'(bus.busy), 0);
      tick();
      check("t1_valid_one_cycle", int'(bus.class_valid), 0);
      check("t1_hold_idx", int'(bus.class_idx), 2);
      check("t1_hold_max", int'($signed(bus.max_value)), 40);
      strobe(77);
      check("t1_err_in_done", int'(bus.err_unexpected), 1);
      check("t1_done_idx_kept", int'(bus.class_idx), 2);
      check("t1_done_max_kept", int'($signed(bus.max_value)), 40);

      // most-negative values with 2-cycle gaps
      pulse_start();
      check("t2_err_cleared", int'(bus.err_unexpected), 0);
      check("t2_busy", int'(bus.busy), 1);
      push_exp(0, -65536);
      for (int i = 0; i < 10; i++) begin
         strobe(-65536);
         if (i < 9) begin
            repeat (2) begin
               tick();
               check("t2_busy_gap", int'(bus.busy), 1);
            end
         end
      end
      check("t2_latency_valid", int'(bus.class_valid), 1);
      tick();

      // abort with a restart after 4 strobes
      pulse_start();
      for (int i = 0; i < 4; i++) strobe(60000);
      pulse_start();
      check("t3_busy_restart", int'(bus.busy), 1);
      push_exp(9, 65535);
      for (int i = 0; i < 10; i++) strobe((i == 9) ? 65535 : (i * 100 - 300));
      check("t3_latency_valid", int'(bus.class_valid), 1);
      tick();

      // reset mid-collect discards partial results
      pulse_start();
      for (int i = 0; i < 6; i++) strobe(1000 + i);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t4_busy", int'(bus.busy), 0);
      check("t4_valid", int'(bus.class_valid), 0);
      check("t4_idx", int'(bus.class_idx), 0);
      check("t4_max", int'($signed(bus.max_value)), 0);
      check("t4_err", int'(bus.err_unexpected), 0);
      for (int i = 0; i < 4; i++) begin
         strobe(2000);
         check("t4_no_valid", int'(bus.class_valid), 0);
         check("t4_idle", int'(bus.busy), 0);
      end
      check("t4_idx_after", int'(bus.class_idx), 0);
      check("t4_max_after", int'($signed(bus.max_value)), 0);

      // sticky error, cleared by start; start beats a coincident strobe
      check("t5_err_set", int'(bus.err_unexpected), 1);
      repeat (3) tick();
      check("t5_err_sticky", int'(bus.err_unexpected), 1);
      pulse_start();
      check("t5_err_clear", int'(bus.err_unexpected), 0);
      bus.start        = 1'b1;
      bus.result_ready = 1'b1;
      bus.result       = 17'(32000);
      tick();
      bus.start        = 1'b0;
      bus.result_ready = 1'b0;
      check("t5_err_not_set", int'(bus.err_unexpected), 0);
      check("t5_busy", int'(bus.busy), 1);
      push_exp(8, 9);
      for (int i = 1; i <= 9; i++) strobe(i);
      check("t5_not_done_at_10", int'(bus.class_valid), 0);
      check("t5_still_busy", int'(bus.busy), 1);
      strobe(3);
      check("t5_done_at_11", int'(bus.class_valid), 1);

      repeat (3) tick();
      check("sb_all_consumed", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
